rpn_stack_calculator: RTL and testbench

Parametrised reverse-Polish calculator with a DEPTH-entry operand stack. It replaces the fixed two-operand flow (A, B, opcode) with push/operate commands, and adds stack-manipulation opcodes and underflow/overflow error reporting. It sits between the board switches/button (DataIn, Enter) and the 7-segment display driver (ToDisplay) plus the flag LEDs.

---
 rtl/rpn_stack_calculator_if.sv | 26 ++
 rtl/rpn_stack_calculator.sv | 192 +++++++++++++++++++
 tb/tb_rpn_stack_calculator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_calculator_if.sv
// Command/display bundle of the RPN calculator: switches and button in,
// display value, flag LEDs, stack occupancy and error indicator out.
interface rpn_stack_calculator_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             Enter;
    logic             IsOp;
    logic [WIDTH-1:0] DataIn;
    logic [WIDTH-1:0] ToDisplay;
    logic [4:0]       Flags;
    logic [CW-1:0]    Count;
    logic             Error;

    modport master (
        output Enter, IsOp, DataIn,
        input  ToDisplay, Flags, Count, Error
    );

    modport slave (
        input  Enter, IsOp, DataIn,
        output ToDisplay, Flags, Count, Error
    );
endinterface

// File: rtl/rpn_stack_calculator.sv
// Reverse-Polish calculator: a DEPTH-entry operand stack driven by push and
// opcode commands, one command per rising edge of the Enter button.
module rpn_stack_calculator #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    rpn_stack_calculator_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_OR    = 3'b010,
        OP_AND   = 3'b011,
        OP_DUP   = 3'b100,
        OP_SWAP  = 3'b101,
        OP_DROP  = 3'b110,
        OP_CLEAR = 3'b111
    } opcode_t;

    logic             enter_q;
    logic             cmd_q;
    logic [CW-1:0]    count_q;
    logic [4:0]       flags_q;
    logic             error_q;
    logic [WIDTH-1:0] stack_mem [DEPTH];

    opcode_t          opcode;
    logic [AW-1:0]    tos_idx;
    logic [AW-1:0]    nos_idx;
    logic [AW-1:0]    push_idx;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;

    logic [WIDTH-1:0] alu_result;
    logic             alu_c;
    logic             alu_v;
    logic [4:0]       flags_next;

    logic             legal;
    logic [CW-1:0]    count_next;
    logic             flags_we;
    logic             wr0_en;
    logic [AW-1:0]    wr0_idx;
    logic [WIDTH-1:0] wr0_data;
    logic             wr1_en;
    logic [AW-1:0]    wr1_idx;
    logic [WIDTH-1:0] wr1_data;

    assign opcode   = opcode_t'(bus.DataIn[2:0]);
    assign tos_idx  = AW'(count_q - CW'(1));
    assign nos_idx  = AW'(count_q - CW'(2));
    assign push_idx = AW'(count_q);
    assign tos      = stack_mem[tos_idx];
    assign nos      = stack_mem[nos_idx];

    // The extra top bit of each full-width result is carry (ADD) or borrow (SUB).
    assign add_full = {1'b0, nos} + {1'b0, tos};
    assign sub_full = {1'b0, nos} - {1'b0, tos};

    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = add_full[WIDTH-1:0];
                alu_c      = add_full[WIDTH];
                alu_v      = (nos[WIDTH-1] == tos[WIDTH-1]) &&
                             (add_full[WIDTH-1] != nos[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_full[WIDTH-1:0];
                alu_c      = sub_full[WIDTH];
                alu_v      = (nos[WIDTH-1] != tos[WIDTH-1]) &&
                             (sub_full[WIDTH-1] != nos[WIDTH-1]);
            end
            OP_OR:   alu_result = nos | tos;
            OP_AND:  alu_result = nos & tos;
            default: alu_result = '0;
        endcase
    end

    assign flags_next = {alu_result[WIDTH-1], (alu_result == '0), alu_c, alu_v, ^alu_result};

    // Decode the pending command into legality, new occupancy and up to two
    // stack writes (SWAP is the only command that needs both ports).
    always_comb begin
        legal      = 1'b0;
        count_next = count_q;
        flags_we   = 1'b0;
        wr0_en     = 1'b0;
        wr0_idx    = push_idx;
        wr0_data   = bus.DataIn;
        wr1_en     = 1'b0;
        wr1_idx    = nos_idx;
        wr1_data   = tos;
        if (!bus.IsOp) begin
            if (count_q < CW'(DEPTH)) begin
                legal      = 1'b1;
                wr0_en     = 1'b1;
                count_next = count_q + CW'(1);
            end
        end else begin
            case (opcode)
                OP_ADD, OP_SUB, OP_OR, OP_AND: begin
                    if (count_q >= CW'(2)) begin
                        legal      = 1'b1;
                        flags_we   = 1'b1;
                        wr0_en     = 1'b1;
                        wr0_idx    = nos_idx;
                        wr0_data   = alu_result;
                        count_next = count_q - CW'(1);
                    end
                end
                OP_DUP: begin
                    if ((count_q != '0) && (count_q < CW'(DEPTH))) begin
                        legal      = 1'b1;
                        wr0_en     = 1'b1;
                        wr0_data   = tos;
                        count_next = count_q + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (count_q >= CW'(2)) begin
                        legal    = 1'b1;
                        wr0_en   = 1'b1;
                        wr0_idx  = tos_idx;
                        wr0_data = nos;
                        wr1_en   = 1'b1;
                    end
                end
                OP_DROP: begin
                    if (count_q != '0) begin
                        legal      = 1'b1;
                        count_next = count_q - CW'(1);
                    end
                end
                OP_CLEAR: begin
                    legal      = 1'b1;
                    count_next = '0;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    // Enter_q resets high so a button held through reset must be released
    // before it can issue a command.
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_q <= 1'b1;
            cmd_q   <= 1'b0;
            count_q <= '0;
            flags_q <= '0;
            error_q <= 1'b0;
        end else begin
            enter_q <= bus.Enter;
            cmd_q   <= bus.Enter & ~enter_q;
            if (cmd_q) begin
                count_q <= count_next;
                error_q <= ~legal;
                if (flags_we) begin
                    flags_q <= flags_next;
                end
            end
        end
    end

    // Stack entries carry no reset; entries at or above Count are don't-care.
    always_ff @(posedge clk) begin
        if (cmd_q && !reset) begin
            if (wr0_en) begin
                stack_mem[wr0_idx] <= wr0_data;
            end
            if (wr1_en) begin
                stack_mem[wr1_idx] <= wr1_data;
            end
        end
    end

    assign bus.ToDisplay = (count_q != '0) ? tos : bus.DataIn;
    assign bus.Flags     = flags_q;
    assign bus.Count     = count_q;
    assign bus.Error     = error_q;
endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Bench for rpn_stack_calculator: a table of commands with hand-derived
// expected results, plus button-hold and reset corner sequences.
module tb_rpn_stack_calculator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    rpn_stack_calculator_if #(.WIDTH(16), .DEPTH(4)) bus ();

    rpn_stack_calculator #(.WIDTH(16), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          isop;
        logic [15:0] data;
        logic [15:0] disp;
        logic [2:0]  cnt;
        logic [4:0]  flg;
        bit          err;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] disp;
        logic [2:0]  cnt;
        logic [4:0]  flg;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add_vec(input string name, input bit isop, input logic [15:0] data,
                           input logic [15:0] disp, input logic [2:0] cnt,
                           input logic [4:0] flg, input bit err);
        vec_t v;
        v.name = name; v.isop = isop; v.data = data;
        v.disp = disp; v.cnt = cnt; v.flg = flg; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic expect_state(input string name, input logic [15:0] disp,
                                input logic [2:0] cnt, input logic [4:0] flg, input bit err);
        exp_t e;
        e.name = name; e.disp = disp; e.cnt = cnt; e.flg = flg; e.err = err;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1 entries");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "display", bus.ToDisplay, e.disp);
        cmp(e.name, "count", {13'd0, bus.Count}, {13'd0, e.cnt});
        cmp(e.name, "flags", {11'd0, bus.Flags}, {11'd0, e.flg});
        cmp(e.name, "error", {15'd0, bus.Error}, {15'd0, e.err});
    endtask

    // One button press: edge k raises Cmd, edge k+1 updates the stack.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        bus.IsOp   = v.isop;
        bus.DataIn = v.data;
        bus.Enter  = 1'b1;
        expect_state(v.name, v.disp, v.cnt, v.flg, v.err);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.Enter = 1'b0;
        check_output();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        bus.Enter  = 1'b0;
        bus.IsOp   = 1'b0;
        bus.DataIn = 16'h0055;

        add_vec("push5",       0, 16'h0005, 16'h0005, 3'd1, 5'b00000, 0);
        add_vec("push3",       0, 16'h0003, 16'h0003, 3'd2, 5'b00000, 0);
        add_vec("sub",         1, 16'h0001, 16'h0002, 3'd1, 5'b00001, 0);
        add_vec("clear1",      1, 16'h0007, 16'h0007, 3'd0, 5'b00001, 0);
        add_vec("push7fff",    0, 16'h7FFF, 16'h7FFF, 3'd1, 5'b00001, 0);
        add_vec("push1",       0, 16'h0001, 16'h0001, 3'd2, 5'b00001, 0);
        add_vec("add_ovf",     1, 16'h0000, 16'h8000, 3'd1, 5'b10011, 0);
        add_vec("push3b",      0, 16'h0003, 16'h0003, 3'd2, 5'b10011, 0);
        add_vec("push5b",      0, 16'h0005, 16'h0005, 3'd3, 5'b10011, 0);
        add_vec("sub_borrow",  1, 16'h0001, 16'hFFFE, 3'd2, 5'b10101, 0);
        add_vec("clear2",      1, 16'h0007, 16'h0007, 3'd0, 5'b10101, 0);
        add_vec("fill1",       0, 16'h0001, 16'h0001, 3'd1, 5'b10101, 0);
        add_vec("fill2",       0, 16'h0002, 16'h0002, 3'd2, 5'b10101, 0);
        add_vec("fill3",       0, 16'h0003, 16'h0003, 3'd3, 5'b10101, 0);
        add_vec("fill4",       0, 16'h0004, 16'h0004, 3'd4, 5'b10101, 0);
        add_vec("push_full",   0, 16'h0005, 16'h0004, 3'd4, 5'b10101, 1);
        add_vec("dup_full",    1, 16'h0004, 16'h0004, 3'd4, 5'b10101, 1);
        add_vec("drop",        1, 16'h0006, 16'h0003, 3'd3, 5'b10101, 0);
        add_vec("clear3",      1, 16'h0007, 16'h0007, 3'd0, 5'b10101, 0);
        add_vec("pushA5",      0, 16'h00A5, 16'h00A5, 3'd1, 5'b10101, 0);
        add_vec("add_under",   1, 16'h0000, 16'h00A5, 3'd1, 5'b10101, 1);
        add_vec("dup",         1, 16'h0004, 16'h00A5, 3'd2, 5'b10101, 0);
        add_vec("swap_same",   1, 16'h0005, 16'h00A5, 3'd2, 5'b10101, 0);
        add_vec("and_a5",      1, 16'h0003, 16'h00A5, 3'd1, 5'b00000, 0);
        add_vec("drop_last",   1, 16'h0006, 16'h0006, 3'd0, 5'b00000, 0);
        add_vec("drop_empty",  1, 16'h0006, 16'h0006, 3'd0, 5'b00000, 1);
        add_vec("dup_empty",   1, 16'h0004, 16'h0004, 3'd0, 5'b00000, 1);
        add_vec("clear_empty", 1, 16'h0007, 16'h0007, 3'd0, 5'b00000, 0);
        add_vec("push0a",      0, 16'h0000, 16'h0000, 3'd1, 5'b00000, 0);
        add_vec("push0b",      0, 16'h0000, 16'h0000, 3'd2, 5'b00000, 0);
        add_vec("or_zero",     1, 16'h0002, 16'h0000, 3'd1, 5'b01000, 0);
        add_vec("push0f0f",    0, 16'h0F0F, 16'h0F0F, 3'd2, 5'b01000, 0);
        add_vec("or",          1, 16'h0002, 16'h0F0F, 3'd1, 5'b00000, 0);
        add_vec("pushffff",    0, 16'hFFFF, 16'hFFFF, 3'd2, 5'b00000, 0);
        add_vec("add_carry",   1, 16'h0000, 16'h0F0E, 3'd1, 5'b00101, 0);
        add_vec("swap_under",  1, 16'h0005, 16'h0F0E, 3'd1, 5'b00101, 1);
        add_vec("push11",      0, 16'h0011, 16'h0011, 3'd2, 5'b00101, 0);
        add_vec("push22",      0, 16'h0022, 16'h0022, 3'd3, 5'b00101, 0);
        add_vec("swap",        1, 16'h0005, 16'h0011, 3'd3, 5'b00101, 0);
        add_vec("drop_swap",   1, 16'h0006, 16'h0022, 3'd2, 5'b00101, 0);
        add_vec("sub_plain",   1, 16'h0001, 16'h0EEC, 3'd1, 5'b00000, 0);
        add_vec("push3c3c",    0, 16'h3C3C, 16'h3C3C, 3'd2, 5'b00000, 0);
        add_vec("and",         1, 16'h0003, 16'h0C2C, 3'd1, 5'b00001, 0);
        add_vec("clear4",      1, 16'h0007, 16'h0007, 3'd0, 5'b00001, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        expect_state("reset", 16'h0055, 3'd0, 5'b00000, 0);
        check_output();

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Enter held for ten cycles still issues exactly one push.
        @(negedge clk);
        bus.IsOp   = 1'b0;
        bus.DataIn = 16'h1234;
        bus.Enter  = 1'b1;
        expect_state("hold_push", 16'h1234, 3'd1, 5'b00001, 0);
        repeat (10) @(negedge clk);
        bus.Enter = 1'b0;
        check_output();

        // Reset with Enter high; releasing reset with Enter still high is silent.
        @(negedge clk);
        bus.DataIn = 16'h0042;
        bus.Enter  = 1'b1;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_state("reset_enter_held", 16'h0042, 3'd0, 5'b00000, 0);
        repeat (4) @(negedge clk);
        check_output();
        bus.Enter = 1'b0;
        @(negedge clk);
        bus.Enter = 1'b1;
        expect_state("repress_push", 16'h0042, 3'd1, 5'b00000, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.Enter = 1'b0;
        check_output();

        v.name = "push8000"; v.isop = 0; v.data = 16'h8000;
        v.disp = 16'h8000; v.cnt = 3'd2; v.flg = 5'b00000; v.err = 0;
        apply_stimulus(v);
        v.name = "add_neg"; v.isop = 1; v.data = 16'h0000;
        v.disp = 16'h8042; v.cnt = 3'd1; v.flg = 5'b10001; v.err = 0;
        apply_stimulus(v);

        // Reset landing on the Cmd cycle discards the push.
        @(negedge clk);
        bus.IsOp   = 1'b0;
        bus.DataIn = 16'h0099;
        bus.Enter  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        bus.Enter = 1'b0;
        expect_state("reset_on_cmd", 16'h0099, 3'd0, 5'b00000, 0);
        check_output();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
